// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the two-master video memory arbiter.
package vram_arbiter_pkg;

    localparam int ADR_W = 24;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_VID  = 2'd1,
        ARB_CPU  = 2'd2,
        ARB_TURN = 2'd3
    } arb_state_t;

    // One-hot owner encoding seen on grant_o: {cpu, vid}
    localparam logic [1:0] GRANT_VID = 2'b01;
    localparam logic [1:0] GRANT_CPU = 2'b10;

endpackage

// File: rtl/vram_arbiter_if.sv
// Pipelined Wishbone bus bundle (if_wb) used by the video memory arbiter.
interface if_wb;
    import vram_arbiter_pkg::*;

    logic             cyc;
    logic             stb;
    logic [ADR_W-1:0] adr;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat_m;
    logic             ack;
    logic             stall;
    logic [DAT_W-1:0] dat_s;

    modport master (
        output cyc, stb, adr, we, sel, dat_m,
        input  ack, stall, dat_s
    );

    modport slave (
        input  cyc, stb, adr, we, sel, dat_m,
        output ack, stall, dat_s
    );

endinterface

// File: rtl/vram_arbiter.sv
// Two-master / one-slave pipelined Wishbone arbiter for video RAM.
// Master 0 (vidbus) is the real-time pixel fetcher and has priority over
// master 1 (cpubus). A grant spans a whole bus cycle and is released via a
// one-cycle turnaround state. Optional macro VRAM_ARB_FAIR_EN adds a CPU
// starvation timer that forces a CPU grant after CPU_WAIT waiting cycles.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int MAX_OUT  = 4,
    parameter int CPU_WAIT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        vidbus,
    if_wb.slave        cpubus,
    if_wb.master       membus,
    output logic [1:0] grant_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             vid_own, cpu_own, own_cyc, own_stb;
    logic             at_max, ack_fwd, accept, cpu_urgent;

    assign vid_own = (state_q == ARB_VID);
    assign cpu_own = (state_q == ARB_CPU);
    assign own_cyc = (vid_own & vidbus.cyc) | (cpu_own & cpubus.cyc);
    assign own_stb = (vid_own & vidbus.stb) | (cpu_own & cpubus.stb);
    assign at_max  = (out_cnt_q == CNT_W'(MAX_OUT));

    // Owner's request passes straight through; strobe is held off once the
    // pipeline is full so the slave never sees more than MAX_OUT in flight.
    assign membus.cyc   = own_cyc;
    assign membus.stb   = own_cyc & own_stb & ~at_max;
    assign membus.adr   = vid_own ? vidbus.adr   : (cpu_own ? cpubus.adr   : '0);
    assign membus.we    = vid_own ? vidbus.we    : (cpu_own ? cpubus.we    : 1'b0);
    assign membus.sel   = vid_own ? vidbus.sel   : (cpu_own ? cpubus.sel   : '0);
    assign membus.dat_m = vid_own ? vidbus.dat_m : (cpu_own ? cpubus.dat_m : '0);

    // Acks only count against real outstanding transfers of a live cycle;
    // stray or post-abort acks are swallowed here.
    assign accept  = membus.stb & ~membus.stall;
    assign ack_fwd = own_cyc & membus.ack & (out_cnt_q != '0);

    assign vidbus.ack   = vid_own & ack_fwd;
    assign cpubus.ack   = cpu_own & ack_fwd;
    assign vidbus.stall = ~vid_own | at_max | membus.stall;
    assign cpubus.stall = ~cpu_own | at_max | membus.stall;
    assign vidbus.dat_s = membus.dat_s;
    assign cpubus.dat_s = membus.dat_s;

    assign grant_o = vid_own ? GRANT_VID : (cpu_own ? GRANT_CPU : 2'b00);

`ifdef VRAM_ARB_FAIR_EN
    localparam int WAIT_W = $clog2(CPU_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              cpu_urgent_q, cpu_urgent_d;

    // Saturating count of cycles the CPU spends requesting without the bus.
    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        cpu_urgent_d = cpu_urgent_q;
        if (cpu_own || state_d == ARB_CPU) begin
            wait_cnt_d   = '0;
            cpu_urgent_d = 1'b0;
        end else if (cpubus.cyc && cpubus.stb) begin
            if (wait_cnt_q != WAIT_W'(CPU_WAIT)) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (wait_cnt_d == WAIT_W'(CPU_WAIT)) begin
                cpu_urgent_d = 1'b1;
            end
        end
    end

    // Starvation timer registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q   <= '0;
            cpu_urgent_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            cpu_urgent_q <= cpu_urgent_d;
        end
    end

    assign cpu_urgent = cpu_urgent_q;
`else
    assign cpu_urgent = 1'b0;
`endif

    // Next owner and outstanding-transfer bookkeeping.
    always_comb begin
        state_d   = state_q;
        out_cnt_d = out_cnt_q;
        if (accept && !ack_fwd) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!accept && ack_fwd) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
        unique case (state_q)
            ARB_IDLE, ARB_TURN: begin
                out_cnt_d = '0;
                if (cpu_urgent && cpubus.cyc) begin
                    state_d = ARB_CPU;
                end else if (vidbus.cyc) begin
                    state_d = ARB_VID;
                end else if (cpubus.cyc) begin
                    state_d = ARB_CPU;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_VID, ARB_CPU: begin
                // Dropping cyc ends the grant; with transfers still in
                // flight this is an abort and their acks are forgotten.
                if (!own_cyc) begin
                    state_d   = ARB_TURN;
                    out_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                out_cnt_d = '0;
            end
        endcase
    end

    // Arbiter state and outstanding counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ARB_IDLE;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule
